s2p_deserializer: RTL and testbench

Serial-to-parallel deserializer: collects a qualified one-bit stream into WIDTH-bit words and presents each word on a valid/ready output port. It is the receive-side counterpart of the team's parallel-to-serial converter. The deserializer sits between a serial link and word-oriented downstream logic. It handles partial-word abort, output backpressure with overflow reporting, and an optional even-parity check.

---
 rtl/s2p_pkg.sv | 5 +
 rtl/s2p_if.sv | 13 +
 rtl/s2p_shift_reg.sv | 39 +++
 rtl/s2p_deserializer.sv | 71 +++++++
 tb/tb_s2p_deserializer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/s2p_pkg.sv
// s2p_pkg: shared FSM state type and default width for s2p_deserializer (parity option: S2P_PARITY_EN)
package s2p_pkg;
   typedef enum logic [0:0] {COLLECT = 1'b0, PARITY = 1'b1} s2p_state_e;
   localparam int S2P_DEF_WIDTH = 4;
endpackage

// File: rtl/s2p_if.sv
// s2p_if: serial input side and word output handshake of s2p_deserializer
interface s2p_if import s2p_pkg::*; #(parameter int WIDTH = S2P_DEF_WIDTH) ();
   logic din;
   logic din_valid;
   logic sync_clr;
   logic [WIDTH-1:0] dout;
   logic dout_valid;
   logic dout_ready;
   logic overflow;
   logic parity_err;
   modport master (output din, din_valid, sync_clr, dout_ready, input dout, dout_valid, overflow, parity_err);
   modport slave (input din, din_valid, sync_clr, dout_ready, output dout, dout_valid, overflow, parity_err);
endinterface

// File: rtl/s2p_shift_reg.sv
// s2p_shift_reg: bit collection shift register and counter; word tap depends on S2P_PARITY_EN
module s2p_shift_reg import s2p_pkg::*; #(
   parameter int WIDTH = S2P_DEF_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             din,
   output logic [WIDTH-1:0] word,
   output logic             done
);
   localparam int CW = $clog2(WIDTH);
   logic [WIDTH-1:0] sr_d, sr_q;
   logic [CW-1:0] cnt_d, cnt_q;
   logic last;
   always_comb begin
      last = cnt_q == CW'(WIDTH - 1);
      done = en && !clr && last;
      sr_d = clr ? '0 : en ? (MSB_FIRST ? {sr_q[WIDTH-2:0], din} : {din, sr_q[WIDTH-1:1]}) : sr_q;
      cnt_d = clr ? '0 : en ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
         cnt_q <= '0;
      end else begin
         sr_q <= sr_d;
         cnt_q <= cnt_d;
      end
   end
   // the parity build delivers one edge later, so it reads the settled register
`ifdef S2P_PARITY_EN
   assign word = sr_q;
`else
   assign word = sr_d;
`endif
endmodule

// File: rtl/s2p_deserializer.sv
// s2p_deserializer: serial-to-parallel word assembler with valid/ready output; S2P_PARITY_EN adds even parity
module s2p_deserializer import s2p_pkg::*; #(
   parameter int WIDTH = S2P_DEF_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic  clk,
   input logic  rst_n,
   s2p_if.slave bus
);
   logic shift_en, done, deliver, accept;
   logic perr_d, perr_q, ovf_d, ovf_q, dout_valid_d, dout_valid_q;
   logic [WIDTH-1:0] word, dout_d, dout_q;
   s2p_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
      .clk(clk),
      .rst_n(rst_n),
      .en(shift_en),
      .clr(bus.sync_clr),
      .din(bus.din),
      .word(word),
      .done(done)
   );
`ifdef S2P_PARITY_EN
   s2p_state_e state_d, state_q;
   logic par_d, par_q, par_chk;
   always_comb begin
      par_chk = state_q == PARITY && bus.din_valid && !bus.sync_clr;
      shift_en = state_q == COLLECT && bus.din_valid && !bus.sync_clr;
      deliver = par_chk && !(par_q ^ bus.din);
      perr_d = par_chk && (par_q ^ bus.din);
      state_d = bus.sync_clr ? COLLECT : done ? PARITY : par_chk ? COLLECT : state_q;
      par_d = (bus.sync_clr || par_chk) ? 1'b0 : shift_en ? par_q ^ bus.din : par_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= COLLECT;
         par_q <= 1'b0;
      end else begin
         state_q <= state_d;
         par_q <= par_d;
      end
   end
`else
   assign shift_en = bus.din_valid && !bus.sync_clr;
   assign deliver = done;
   assign perr_d = 1'b0;
`endif
   // a word lands only if the slot is empty or being drained on the same edge
   always_comb begin
      accept = !dout_valid_q || bus.dout_ready;
      dout_d = (deliver && accept) ? word : dout_q;
      dout_valid_d = (deliver && accept) ? 1'b1 : bus.dout_ready ? 1'b0 : dout_valid_q;
      ovf_d = deliver && !accept;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= '0;
         dout_valid_q <= 1'b0;
         ovf_q <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         dout_q <= dout_d;
         dout_valid_q <= dout_valid_d;
         ovf_q <= ovf_d;
         perr_q <= perr_d;
      end
   end
   assign bus.dout = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.overflow = ovf_q;
   assign bus.parity_err = perr_q;
endmodule

// File: tb/tb_s2p_deserializer.sv
// tb_s2p_deserializer: MSB-first and LSB-first instances fed identical streams, scoreboard plus direct checks
module tb_s2p_deserializer;
   logic clk = 1'b0;
   logic rst_n, din, din_valid, sync_clr, dout_ready;
   int n_chk = 0, n_fail = 0, ovf_cnt = 0;
   logic [3:0] q_msb[$], q_lsb[$];
   logic pv_a, pv_b, pr_a;
   typedef struct {logic [3:0] w; int gap; logic [3:0] em; logic [3:0] el;} vec_t;
   vec_t tbl[5];
   always #5 clk = ~clk;
   s2p_if #(.WIDTH(4)) ia ();
   s2p_if #(.WIDTH(4)) ib ();
   assign ia.din = din;
   assign ia.din_valid = din_valid;
   assign ia.sync_clr = sync_clr;
   assign ia.dout_ready = dout_ready;
   assign ib.din = din;
   assign ib.din_valid = din_valid;
   assign ib.sync_clr = sync_clr;
   assign ib.dout_ready = dout_ready;
   s2p_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(ia));
   s2p_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(ib));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [3:0] act);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got word %0h, required no word", name, act);
   endtask

   // drive one cycle of inputs; outputs are sampled on the falling edge
   task automatic step(input logic d, input logic v, input logic c);
      din = d;
      din_valid = v;
      sync_clr = c;
      @(negedge clk);
      if (rst_n) begin
         if (ia.dout_valid && (!pv_a || pr_a)) begin
            if (q_msb.size() == 0) unexpected("sb_msb", ia.dout);
            else chk("sb_msb", ia.dout, q_msb.pop_front());
         end
         if (ib.dout_valid && (!pv_b || pr_a)) begin
            if (q_lsb.size() == 0) unexpected("sb_lsb", ib.dout);
            else chk("sb_lsb", ib.dout, q_lsb.pop_front());
         end
         ovf_cnt += int'(ia.overflow) + int'(ib.overflow);
         pv_a = ia.dout_valid;
         pv_b = ib.dout_valid;
         pr_a = dout_ready;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [3:0] w, input int gap, input logic [3:0] em, input logic [3:0] el,
                            input bit exp_del, input bit chk_gaps, input logic rdy_last);
      logic [4:0] b;
      int nb;
`ifdef S2P_PARITY_EN
      b = {w, ^w};
      nb = 5;
`else
      b = {1'b0, w};
      nb = 4;
`endif
      if (exp_del) begin
         q_msb.push_back(em);
         q_lsb.push_back(el);
      end
      for (int i = nb - 1; i >= 0; i--) begin
         if (i == 0) dout_ready = rdy_last;
         step(b[i], 1'b1, 1'b0);
         if (i > 0) begin
            if (chk_gaps) chk("gap_idle", ia.dout_valid, 0);
            repeat (gap) step(1'b0, 1'b0, 1'b0);
         end
      end
      if (exp_del) begin
         chk("latency_valid", ia.dout_valid, 1);
         chk("dout_msb", ia.dout, em);
         chk("dout_lsb", ib.dout, el);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      din = 1'b0;
      din_valid = 1'b0;
      sync_clr = 1'b0;
      dout_ready = 1'b1;
      pv_a = 1'b0;
      pv_b = 1'b0;
      pr_a = 1'b0;
      tbl[0] = '{4'b1011, 0, 4'hB, 4'hD};
      tbl[1] = '{4'b1011, 3, 4'hB, 4'hD};
      tbl[2] = '{4'b1100, 1, 4'hC, 4'h3};
      tbl[3] = '{4'b0001, 0, 4'h1, 4'h8};
      tbl[4] = '{4'b0110, 2, 4'h6, 4'h6};
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout", ia.dout, 0);
      chk("rst_valid", ia.dout_valid, 0);
      chk("rst_ovf", ia.overflow, 0);
      chk("rst_perr", ia.parity_err, 0);
      chk("rst_valid_lsb", ib.dout_valid, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send_word(tbl[i].w, tbl[i].gap, tbl[i].em, tbl[i].el, 1, 1, 1'b1);
         step(1'b0, 1'b0, 1'b0);
         chk("valid_one_cycle", ia.dout_valid, 0);
      end
      // backpressure: second word overflows, third lands as the slot drains
      dout_ready = 1'b0;
      send_word(4'hA, 0, 4'hA, 4'h5, 1, 0, 1'b0);
      send_word(4'h5, 0, 4'h0, 4'h0, 0, 0, 1'b0);
      chk("ovf_pulse", ia.overflow, 1);
      chk("ovf_pulse_lsb", ib.overflow, 1);
      chk("ovf_hold_dout", ia.dout, 4'hA);
      chk("ovf_hold_lsb", ib.dout, 4'h5);
      step(1'b0, 1'b0, 1'b0);
      chk("ovf_one_cycle", ia.overflow, 0);
      chk("ovf_hold_valid", ia.dout_valid, 1);
      send_word(4'h3, 0, 4'h3, 4'hC, 1, 0, 1'b1);
      chk("no_ovf_on_drain", ia.overflow, 0);
      step(1'b0, 1'b0, 1'b0);
      // abort after two bits
      dout_ready = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      chk("clr_no_word", ia.dout_valid, 0);
      send_word(4'hC, 0, 4'hC, 4'h3, 1, 1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      // abort on the completing edge while a pending word drains
      send_word(4'h9, 0, 4'h9, 4'h9, 1, 0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
`ifdef S2P_PARITY_EN
      step(1'b0, 1'b1, 1'b0);
`endif
      dout_ready = 1'b1;
      step(1'b1, 1'b1, 1'b1);
      chk("clr_win_valid", ia.dout_valid, 0);
      chk("clr_keep_dout", ia.dout, 4'h9);
      chk("clr_win_ovf", ia.overflow, 0);
      send_word(4'h7, 0, 4'h7, 4'hE, 1, 1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      // asynchronous reset mid-word with a word pending
      dout_ready = 1'b0;
      send_word(4'h6, 0, 4'h6, 4'h6, 1, 0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("arst_dout", ia.dout, 0);
      chk("arst_valid", ia.dout_valid, 0);
      chk("arst_dout_lsb", ib.dout, 0);
      chk("arst_valid_lsb", ib.dout_valid, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      pv_a = 1'b0;
      pv_b = 1'b0;
      dout_ready = 1'b1;
      send_word(4'hA, 0, 4'hA, 4'h5, 1, 1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      // back-to-back words, gap checks confirm one delivery per word period
      send_word(4'hF, 0, 4'hF, 4'hF, 1, 1, 1'b1);
      send_word(4'h0, 0, 4'h0, 4'h0, 1, 1, 1'b1);
      send_word(4'h9, 0, 4'h9, 4'h9, 1, 1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
`ifdef S2P_PARITY_EN
      q_msb.push_back(4'hB);
      q_lsb.push_back(4'hD);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("par_wait", ia.dout_valid, 0);
      step(1'b1, 1'b1, 1'b0);
      chk("par_ok_valid", ia.dout_valid, 1);
      chk("par_ok_dout", ia.dout, 4'hB);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("par_err_pulse", ia.parity_err, 1);
      chk("par_err_valid", ia.dout_valid, 0);
      chk("par_err_no_ovf", ia.overflow, 0);
      step(1'b0, 1'b0, 1'b0);
      chk("par_err_one_cycle", ia.parity_err, 0);
`else
      chk("perr_tied", ia.parity_err, 0);
`endif
      step(1'b0, 1'b0, 1'b0);
      chk("sb_drained", q_msb.size() + q_lsb.size(), 0);
      chk("ovf_total", ovf_cnt, 2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
